sbox_share_sched: RTL and testbench

//  - Time-multiplexes LANES aes_sbox instances between two 128-bit SubBytes requesters (SNOW-V FSM rounds R2/R3 or key path).
//  - Round-robin arbitration. Each accepted block is substituted LANES bytes per cycle in an internal buffer.
//  - The result is returned on a valid/ready response port, tagged with the requester id.

---
 rtl/sbox_share_sched.sv | 175 +++++++++++++++++
 tb/tb_sbox_share_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_share_sched.sv
// sbox_share_sched: shares LANES AES S-box instances between two 128-bit
// SubBytes requesters. The arbiter is round-robin. An accepted block is
// substituted in place, LANES bytes per cycle. The result is returned on a
// valid/ready port, tagged with the id of the requester that owns it.
//
// Optional feature: define SBOX_SCHED_SHIFTROWS_EN to apply AES ShiftRows to
// the response. This is wiring only; the response is then SubBytes+ShiftRows.
// In the default build the response is SubBytes only.

// Combinational AES forward S-box, implemented as a 256-entry lookup table.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    // Entry 0 sits in the most significant byte. Entry x is therefore at
    // byte position 255-x, which is ~x.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = SBOX_TABLE[{~din, 3'b000} +: 8];
endmodule

module sbox_share_sched #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_data,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_id,
    output logic         busy
);
    localparam int BEATS = 16 / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [CW-1:0] cnt_reg;
    logic [7:0]    buf_reg [16];
    logic          rsp_id_reg;
    logic          last_id_reg;

    logic          grant_valid;
    logic          grant_id;
    logic          accept;
    logic          cnt_last;

    logic [3:0]    lane_idx [LANES];
    logic [7:0]    lane_in  [LANES];
    logic [7:0]    lane_out [LANES];

    // Choose the requester to serve. When both requesters are valid, the one
    // not served last time wins.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_id_reg;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Accept only from IDLE. Reset blocks any handshake that reset would
    // otherwise override.
    assign accept     = (state_reg == IDLE) && grant_valid && !rst;
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    assign cnt_last = (cnt_reg == CW'(BEATS - 1));

    // The S-box lanes read the current beat's byte slice. With LANES=16,
    // cnt is always 0, so all bytes go through in one RUN cycle.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_idx[gi] = 4'((int'(cnt_reg) * LANES) + gi);
        assign lane_in[gi]  = buf_reg[lane_idx[gi]];

        aes_sbox u_sbox (
            .din  (lane_in[gi]),
            .dout (lane_out[gi])
        );
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic: IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (cnt_last)  state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Datapath. On accept, capture the block and its owner. In RUN,
    // substitute one beat of bytes in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                buf_reg[i] <= 8'h00;
            end
            cnt_reg     <= '0;
            rsp_id_reg  <= 1'b0;
            last_id_reg <= 1'b1;
        end else if (accept) begin
            for (int i = 0; i < 16; i++) begin
                buf_reg[i] <= grant_id ? req1_data[8*i +: 8] : req0_data[8*i +: 8];
            end
            rsp_id_reg  <= grant_id;
            last_id_reg <= grant_id;
            cnt_reg     <= '0;
        end else if (state_reg == RUN) begin
            for (int l = 0; l < LANES; l++) begin
                buf_reg[lane_idx[l]] <= lane_out[l];
            end
            cnt_reg <= cnt_last ? '0 : cnt_reg + 1'b1;
        end
    end

`ifdef SBOX_SCHED_SHIFTROWS_EN
    // ShiftRows on a column-major state. Output byte r+4c takes row r from
    // column (c+r)%4.
    for (genvar gi = 0; gi < 16; gi++) begin : g_out
        assign rsp_data[8*gi +: 8] = buf_reg[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
    end
`else
    // SubBytes only: the buffer is presented unchanged.
    for (genvar gi = 0; gi < 16; gi++) begin : g_out
        assign rsp_data[8*gi +: 8] = buf_reg[gi];
    end
`endif

    assign rsp_valid = (state_reg == DONE) && !rst;
    assign rsp_id    = rsp_id_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_sbox_share_sched.sv
// Testbench for sbox_share_sched. Four instances run side by side, with
// LANES = 4, 1, 2 and 16. A reference model derives the S-box from
// GF(2^8) inversion plus the affine map, and applies the ShiftRows rule when
// SBOX_SCHED_SHIFTROWS_EN is defined. A round-robin model predicts the grant.
module tb_sbox_share_sched;
    logic         clk;
    logic         rst   [4];
    logic         v0    [4];
    logic         v1    [4];
    logic         rr    [4];
    logic [127:0] d0    [4];
    logic [127:0] d1    [4];
    logic         rdy0  [4];
    logic         rdy1  [4];
    logic         rv    [4];
    logic         rid   [4];
    logic         bsy   [4];
    logic [127:0] rd    [4];

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   sbox_tab [256];
    int           ref_last [4];

    for (genvar gk = 0; gk < 4; gk++) begin : g_dut
        localparam int LN = (gk == 0) ? 4 : (gk == 1) ? 1 : (gk == 2) ? 2 : 16;
        sbox_share_sched #(.LANES(LN)) u_dut (
            .clk        (clk),
            .rst        (rst[gk]),
            .req0_valid (v0[gk]),
            .req0_ready (rdy0[gk]),
            .req0_data  (d0[gk]),
            .req1_valid (v1[gk]),
            .req1_ready (rdy1[gk]),
            .req1_data  (d1[gk]),
            .rsp_valid  (rv[gk]),
            .rsp_ready  (rr[gk]),
            .rsp_data   (rd[gk]),
            .rsp_id     (rid[gk]),
            .busy       (bsy[gk])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    function automatic int lanes_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 1 : (k == 2) ? 2 : 16;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] sbox_calc(input int x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] expect_block(input logic [127:0] din);
        logic [7:0]   s [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = sbox_tab[din[8*i +: 8]];
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
`ifdef SBOX_SCHED_SHIFTROWS_EN
                o[8*(r+4*c) +: 8] = s[r + 4*((c + r) % 4)];
`else
                o[8*(r+4*c) +: 8] = s[r + 4*c];
`endif
            end
        end
        return o;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Wait for an accept, then for the response. Return at the first cycle
    // in which rsp_valid is high. The granted valid can be dropped one
    // cycle after the accept.
    task automatic serve(input int k, input bit drop, output int gid, output logic [127:0] gdata,
                         output int lat, output logic [127:0] adata);
        int n;
        n     = 0;
        gid   = -1;
        lat   = 0;
        gdata = '0;
        adata = '0;
        while (!rdy0[k] && !rdy1[k] && n < 100) begin
            step();
            n++;
        end
        if (!rdy0[k] && !rdy1[k]) begin
            check("accept_timeout", 128'(1'b0), 128'(1'b1));
            return;
        end
        check("one_ready", 128'(rdy0[k] & rdy1[k]), 128'(1'b0));
        gid   = rdy1[k] ? 1 : 0;
        adata = rdy1[k] ? d1[k] : d0[k];
        do begin
            @(negedge clk);
            if (drop && lat == 0) begin
                if (gid == 1) v1[k] = 1'b0;
                else          v0[k] = 1'b0;
            end
            #1;
            lat++;
            check("busy_after_accept", 128'(bsy[k]), 128'(1'b1));
            check("no_ready_while_busy", 128'(rdy0[k] | rdy1[k]), 128'(1'b0));
        end while (!rv[k] && lat < 100);
        check("rsp_timeout", 128'(rv[k]), 128'(1'b1));
        gdata = rd[k];
    endtask

    task automatic finish_rsp(input int k);
        rr[k] = 1'b1;
        step();
        check("rsp_released", 128'(rv[k]), 128'(1'b0));
    endtask

    initial begin
        int           gid;
        int           lat;
        int           exp_id;
        logic [127:0] gdata;
        logic [127:0] adata;
        logic [127:0] hold;
        logic [127:0] idx_data;
        logic [7:0]   exp_b1;

        for (int x = 0; x < 256; x++) sbox_tab[x] = sbox_calc(x);

        for (int k = 0; k < 4; k++) begin
            rst[k] = 1'b1; v0[k] = 1'b0; v1[k] = 1'b0; rr[k] = 1'b0;
            d0[k] = '0; d1[k] = '0; ref_last[k] = 1;
        end
        v0[0] = 1'b1;
        rr[0] = 1'b1;

        // Reset state: no ready, even though req0 is valid.
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            check("reset_rdy0", 128'(rdy0[k]), 128'(1'b0));
            check("reset_rdy1", 128'(rdy1[k]), 128'(1'b0));
            check("reset_rsp_valid", 128'(rv[k]), 128'(1'b0));
            check("reset_busy", 128'(bsy[k]), 128'(1'b0));
            check("reset_rsp_data", rd[k], 128'h0);
            check("reset_rsp_id", 128'(rid[k]), 128'(1'b0));
        end
        for (int k = 0; k < 4; k++) rst[k] = 1'b0;
        #1;

        // All-zero block from requester 0.
        serve(0, 1'b1, gid, gdata, lat, adata);
        check("zero_id", 128'(gid), 128'(0));
        check("zero_latency", 128'(lat), 128'(5));
        check("zero_data", gdata, {16{8'h63}});
        check("zero_rsp_id", 128'(rid[0]), 128'(1'b0));
        $display("txn zero: id=%0d lat=%0d data=%h", gid, lat, gdata);

        // Reset, then both requesters stay valid: service alternates 0,1,0,1.
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        v0[0] = 1'b1; v1[0] = 1'b1;
        d0[0] = {16{8'h53}}; d1[0] = {16{8'h01}};
        ref_last[0] = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            serve(0, 1'b0, gid, gdata, lat, adata);
            exp_id = 1 - ref_last[0];
            check("rr_id", 128'(gid), 128'(exp_id));
            check("rr_data_const", gdata, (i % 2 == 0) ? {16{8'hED}} : {16{8'h7C}});
            check("rr_data_model", gdata, expect_block(adata));
            check("rr_rsp_id", 128'(rid[0]), 128'(exp_id));
            ref_last[0] = exp_id;
            $display("txn rr%0d: id=%0d lat=%0d data=%h", i, gid, lat, gdata);
        end
        finish_rsp(0);

        // Backpressure: the response is held while req1 waits with ready low.
        v1[0] = 1'b0;
        v0[0] = 1'b1;
        d0[0] = {$urandom, $urandom, $urandom, $urandom};
        rr[0] = 1'b0;
        #1;
        serve(0, 1'b1, gid, gdata, lat, adata);
        check("bp_id", 128'(gid), 128'(0));
        check("bp_data", gdata, expect_block(adata));
        ref_last[0] = 0;
        hold = gdata;
        v1[0] = 1'b1;
        d1[0] = {$urandom, $urandom, $urandom, $urandom};
        #1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid_held", 128'(rv[0]), 128'(1'b1));
            check("bp_data_held", rd[0], hold);
            check("bp_id_held", 128'(rid[0]), 128'(1'b0));
            check("bp_req1_blocked", 128'(rdy1[0]), 128'(1'b0));
        end
        rr[0] = 1'b1;
        step();
        check("bp_next_accept", 128'(rdy1[0]), 128'(1'b1));
        serve(0, 1'b1, gid, gdata, lat, adata);
        check("bp_req1_id", 128'(gid), 128'(1));
        check("bp_req1_data", gdata, expect_block(adata));
        ref_last[0] = 1;
        $display("txn backpressure: id=%0d lat=%0d data=%h", gid, lat, gdata);
        finish_rsp(0);

        // Reset during the second RUN cycle: the block is discarded and
        // req0 is favoured again.
        v0[0] = 1'b1;
        v1[0] = 1'b0;
        d0[0] = {16{8'hA5}};
        #1;
        check("mr_accept", 128'(rdy0[0]), 128'(1'b1));
        @(negedge clk);
        v1[0] = 1'b1;
        #1;
        @(negedge clk);
        rst[0] = 1'b1;
        #1;
        @(negedge clk);
        rst[0] = 1'b0;
        d0[0] = {$urandom, $urandom, $urandom, $urandom};
        #1;
        check("mr_busy", 128'(bsy[0]), 128'(1'b0));
        check("mr_rsp_valid", 128'(rv[0]), 128'(1'b0));
        check("mr_rdy0", 128'(rdy0[0]), 128'(1'b1));
        check("mr_rdy1", 128'(rdy1[0]), 128'(1'b0));
        serve(0, 1'b1, gid, gdata, lat, adata);
        check("mr_first_id", 128'(gid), 128'(0));
        check("mr_first_data", gdata, expect_block(adata));
        finish_rsp(0);
        serve(0, 1'b1, gid, gdata, lat, adata);
        check("mr_second_id", 128'(gid), 128'(1));
        check("mr_second_data", gdata, expect_block(adata));
        ref_last[0] = 1;
        $display("txn midreset: id=%0d lat=%0d data=%h", gid, lat, gdata);
        finish_rsp(0);

        // Byte i = i, which exposes the byte ordering and ShiftRows.
        for (int i = 0; i < 16; i++) idx_data[8*i +: 8] = 8'(i);
`ifdef SBOX_SCHED_SHIFTROWS_EN
        exp_b1 = 8'h6B;
`else
        exp_b1 = 8'h7C;
`endif
        v0[0] = 1'b1;
        d0[0] = idx_data;
        #1;
        serve(0, 1'b1, gid, gdata, lat, adata);
        check("idx_byte1", 128'(gdata[15:8]), 128'(exp_b1));
        check("idx_byte0", 128'(gdata[7:0]), 128'(8'h63));
        check("idx_model", gdata, expect_block(idx_data));
        ref_last[0] = 0;
        $display("txn index: id=%0d lat=%0d data=%h", gid, lat, gdata);
        finish_rsp(0);

        // Random sweep over all four lane widths.
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 8; t++) begin
                int stall;
                v0[k] = 1'($urandom_range(0, 1));
                v1[k] = 1'($urandom_range(0, 1));
                if (!v0[k] && !v1[k]) v0[k] = 1'b1;
                d0[k] = {$urandom, $urandom, $urandom, $urandom};
                d1[k] = {$urandom, $urandom, $urandom, $urandom};
                rr[k] = 1'b0;
                if (v0[k] && v1[k]) exp_id = 1 - ref_last[k];
                else                exp_id = v1[k] ? 1 : 0;
                #1;
                serve(k, 1'b1, gid, gdata, lat, adata);
                check("sweep_id", 128'(gid), 128'(exp_id));
                check("sweep_latency", 128'(lat), 128'(16 / lanes_of(k) + 1));
                check("sweep_data", gdata, expect_block(exp_id == 1 ? d1[k] : d0[k]));
                check("sweep_rsp_id", 128'(rid[k]), 128'(exp_id));
                ref_last[k] = exp_id;
                $display("txn sweep lanes=%0d #%0d: id=%0d lat=%0d data=%h", lanes_of(k), t, gid, lat, gdata);
                stall = $urandom_range(0, 3);
                for (int s = 0; s < stall; s++) begin
                    step();
                    check("sweep_hold_data", rd[k], gdata);
                    check("sweep_hold_valid", 128'(rv[k]), 128'(1'b1));
                end
                finish_rsp(k);
            end
            v0[k] = 1'b0;
            v1[k] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
